// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared fetch-unit definitions: default PC width, fetch operations and
// the instruction length decode used by the prefetch queue.
package fetch_prefetch_queue_pkg;

    localparam int DEF_PC_WIDTH = 14;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_SEQ,
        FETCH_JUMP
    } fetch_operation_t;

    // Bit 1 of the first byte marks a two-byte instruction.
    function automatic logic [1:0] inst_len(input logic [7:0] first);
        return first[1] ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/fetch_byte_queue.sv
// Circular byte FIFO feeding decode: up to two bytes pushed and popped
// per cycle, with the two head bytes and the fill count exposed.
module fetch_byte_queue #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_async,
    input  logic          flush,
    input  logic [1:0]    push_n,
    input  logic [15:0]   push_data,
    input  logic [1:0]    pop_n,
    output logic [7:0]    head0,
    output logic [7:0]    head1,
    output logic [CW-1:0] count
);

    logic [7:0]    slots [DEPTH];
    logic [AW-1:0] rd;
    logic [AW-1:0] wr;

    assign head0 = slots[rd];
    assign head1 = slots[rd + AW'(1)];

    // Storage carries no reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push_n != 2'd0) begin
                slots[wr] <= push_data[7:0];
            end
            if (push_n == 2'd2) begin
                slots[wr + AW'(1)] <= push_data[15:8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            rd    <= rd + AW'(pop_n);
            wr    <= wr + AW'(push_n);
            count <= count + CW'(push_n) - CW'(pop_n);
        end
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch unit: streams 16-bit memory words into a byte queue ahead of the
// PC and presents the variable-length instruction at the queue head.
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int QUEUE_BYTES = 4
) (
    input  logic                               clk,
    input  logic                               rst_async,
    input  logic                               consume,
    input  logic                               redirect,
    input  logic [PC_WIDTH-1:0]                redirect_pc,
    output logic                               inst_valid,
    output logic [15:0]                        inst,
    output logic [PC_WIDTH-1:0]                inst_pc,
    output logic [$clog2(QUEUE_BYTES+1)-1:0]   occupancy,
    output logic                               mem_req,
    output logic [PC_WIDTH-2:0]                mem_addr,
    input  logic [15:0]                        mem_data
);

    localparam int CW = $clog2(QUEUE_BYTES + 1);

    logic [PC_WIDTH-2:0] fetch_ptr;
    logic                inflight;
    logic                drop;
    logic                skip;
    logic [7:0]          head0;
    logic [7:0]          head1;
    logic [1:0]          len;
    logic [1:0]          push_n;
    logic [1:0]          pop_n;
    logic [15:0]         push_data;
    logic                issue_ok;
    logic                take;
    logic                flush;
    fetch_operation_t    op;

    fetch_byte_queue #(
        .DEPTH(QUEUE_BYTES)
    ) u_queue (
        .clk       (clk),
        .rst_async (rst_async),
        .flush     (flush),
        .push_n    (push_n),
        .push_data (push_data),
        .pop_n     (pop_n),
        .head0     (head0),
        .head1     (head1),
        .count     (occupancy)
    );

    assign len        = inst_len(head0);
    assign inst_valid = (occupancy != '0)
                      && (len == 2'd1 || occupancy > CW'(1));
    assign inst       = (len == 2'd2) ? {head1, head0} : {8'h00, head0};

    // Room must remain for the word in flight plus the one issued now.
    assign issue_ok = (int'(occupancy) + (inflight ? 2 : 0) + 2)
                      <= QUEUE_BYTES;
    assign mem_req  = issue_ok & ~rst_async;
    assign mem_addr = fetch_ptr;

    always_comb begin
        op = FETCH_IDLE;
        unique case (1'b1)
            redirect:             op = FETCH_JUMP;
            !redirect && mem_req: op = FETCH_SEQ;
            default:              op = FETCH_IDLE;
        endcase
    end

    assign flush = (op == FETCH_JUMP);
    assign take  = consume & inst_valid & ~flush;
    assign pop_n = take ? len : 2'd0;

    always_comb begin
        push_n    = 2'd0;
        push_data = mem_data;
        if (!flush && inflight && !drop) begin
            if (skip) begin
                push_n    = 2'd1;
                push_data = {8'h00, mem_data[15:8]};
            end else begin
                push_n    = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            inst_pc   <= '0;
            fetch_ptr <= '0;
            inflight  <= 1'b0;
            drop      <= 1'b0;
            skip      <= 1'b0;
        end else begin
            inflight <= mem_req;
            if (flush) begin
                inst_pc   <= redirect_pc;
                fetch_ptr <= redirect_pc[PC_WIDTH-1:1];
                skip      <= redirect_pc[0];
                // A word requested now answers for the old stream.
                drop      <= mem_req;
            end else begin
                if (op == FETCH_SEQ) begin
                    fetch_ptr <= fetch_ptr + (PC_WIDTH-1)'(1);
                end
                if (take) begin
                    inst_pc <= inst_pc + PC_WIDTH'(len);
                end
                if (inflight) begin
                    if (drop) begin
                        drop <= 1'b0;
                    end else begin
                        skip <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomised bench for fetch_prefetch_queue against a byte-queue model.
module tb_fetch_prefetch_queue;

    localparam int PW = 14;
    localparam int QB = 4;
    localparam int NCYC = 4000;

    logic        clk = 1'b0;
    logic        rst_async = 1'b1;
    logic        consume = 1'b0;
    logic        redirect = 1'b0;
    logic [13:0] redirect_pc = '0;
    logic [15:0] mem_data = '0;
    logic        inst_valid;
    logic [15:0] inst;
    logic [13:0] inst_pc;
    logic [2:0]  occupancy;
    logic        mem_req;
    logic [12:0] mem_addr;

    fetch_prefetch_queue #(
        .PC_WIDTH    (PW),
        .QUEUE_BYTES (QB)
    ) dut (
        .clk         (clk),
        .rst_async   (rst_async),
        .consume     (consume),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .occupancy   (occupancy),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [15:0] tbmem [8192];

    // Reference: bytes in fetch order, plus the outstanding read.
    logic [7:0] mq[$];
    int m_pc, m_fptr, m_pend, m_paddr, m_drop, m_skip;
    int e_len, e_valid, e_req;
    logic        rsp_due;
    logic [12:0] rsp_addr;

    task automatic model_reset();
        mq.delete();
        m_pc = 0; m_fptr = 0; m_pend = 0; m_paddr = 0;
        m_drop = 0; m_skip = 0;
    endtask

    task automatic model_check();
        int occ;
        logic [15:0] e_inst;
        occ = mq.size();
        e_len = (occ > 0 && mq[0][1]) ? 2 : 1;
        e_valid = (occ >= 1 && (e_len == 1 || occ >= 2)) ? 1 : 0;
        e_req = (occ + 2 * m_pend + 2 <= QB) ? 1 : 0;
        chk("occupancy", 32'(occupancy), occ);
        chk("inst_valid", 32'(inst_valid), e_valid);
        chk("inst_pc", 32'(inst_pc), m_pc);
        chk("mem_req", 32'(mem_req), e_req);
        if (e_req == 1) chk("mem_addr", 32'(mem_addr), m_fptr);
        if (e_valid == 1) begin
            e_inst = (e_len == 2) ? {mq[1], mq[0]} : {8'h00, mq[0]};
            chk("inst", 32'(inst), 32'(e_inst));
        end
    endtask

    task automatic model_step();
        logic [15:0] w;
        w = tbmem[m_paddr];
        if (redirect) begin
            mq.delete();
            m_pc = int'(redirect_pc);
            m_fptr = int'(redirect_pc) / 2;
            m_skip = int'(redirect_pc[0]);
            m_drop = e_req;
            m_pend = e_req;
        end else begin
            if (consume && e_valid == 1) begin
                repeat (e_len) void'(mq.pop_front());
                m_pc = (m_pc + e_len) % (1 << PW);
            end
            if (m_pend == 1) begin
                if (m_drop == 1) begin
                    m_drop = 0;
                end else begin
                    if (m_skip == 0) mq.push_back(w[7:0]);
                    mq.push_back(w[15:8]);
                    m_skip = 0;
                end
            end
            m_pend = e_req;
            if (e_req == 1) begin
                m_paddr = m_fptr;
                m_fptr = (m_fptr + 1) % (1 << (PW - 1));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(inst_valid), 0);
        chk({tag, "_occ"}, 32'(occupancy), 0);
        chk({tag, "_req"}, 32'(mem_req), 0);
        chk({tag, "_pc"}, 32'(inst_pc), 0);
    endtask

    task automatic pick_inputs(input int cyc);
        int r;
        consume = 1'b1;
        redirect = 1'b0;
        redirect_pc = 14'($urandom);
        if (cyc >= 30 && cyc < 60) begin
            consume = (cyc == 45) ? 1'b1 : 1'b0;
        end else if (cyc == 61) begin
            redirect = 1'b1; redirect_pc = 14'd5;
        end else if (cyc == 70) begin
            redirect = 1'b1; redirect_pc = 14'd3;
        end else if (cyc == 80) begin
            redirect = 1'b1; redirect_pc = 14'h3FFF;
        end else if (cyc == 100 || cyc == 101) begin
            redirect = 1'b1; redirect_pc = 14'(cyc + 7);
        end else if (cyc > 110) begin
            consume = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 14) == 0);
            r = $urandom_range(0, 7);
            if (r == 0) redirect_pc = 14'h3FFF;
            else if (r == 1) redirect_pc = 14'h3FFE;
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) tbmem[i] = 16'($urandom);
        tbmem[0] = 16'h0201;
        tbmem[1] = 16'h0300;
        tbmem[2] = 16'h0402;
        tbmem[8191] = 16'h0700;
        model_reset();
        rsp_due = 1'b0;
        rsp_addr = '0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_async = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            pick_inputs(cyc);
            mem_data = rsp_due ? tbmem[rsp_addr] : 16'($urandom);
            #3;
            model_check();
            rsp_due = mem_req;
            rsp_addr = mem_addr;
            if (cyc == 2000) begin
                #2 rst_async = 1'b1;
                #1 check_reset_outputs("midreset");
                @(posedge clk);
                #1 rst_async = 1'b0;
                model_reset();
                rsp_due = 1'b0;
            end else begin
                @(posedge clk);
                model_step();
                #1;
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
